// File: rtl/cursor_compositor_pkg.sv
// cursor_compositor_pkg
//   Shared constants for the cursor compositor: default raster size, the
//   MODE encodings and the shadow-register layout latched once per frame.
package cursor_compositor_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_OUTLINE = 2'd1;
    localparam logic [1:0] MODE_CROSS   = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    // Cursor state used for drawing; only updated at the frame latch event.
    typedef struct packed {
        logic [9:0] ph;
        logic [9:0] pv;
        logic [2:0] bot;
        logic [1:0] mode;
    } shadow_t;

endpackage

// File: rtl/cursor_hit.sv
// cursor_hit
//   Combinational cursor geometry. Decides whether raster position
//   (conth, contv) is covered by the cursor shape selected by mode.
//   Ports:
//     conth, contv : raster counters
//     ph, pv       : shadow cursor position (top-left anchor)
//     mode         : shape select (solid / outline / crosshair / off)
//     hit          : cursor covers this position (active gating done by caller)
module cursor_hit
    import cursor_compositor_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CUR_SIZE = 8
) (
    input  logic [9:0] conth,
    input  logic [9:0] contv,
    input  logic [9:0] ph,
    input  logic [9:0] pv,
    input  logic [1:0] mode,
    output logic       hit
);

    localparam logic [10:0] HA = 11'(H_ACTIVE);
    localparam logic [10:0] VA = 11'(V_ACTIVE);
    localparam logic [10:0] CS = 11'(CUR_SIZE);

    // 11-bit arithmetic so a box near column/line 1023 cannot wrap to 0.
    logic [10:0] h, v, h0, v0, h1, v1;
    logic        in_box, on_edge, pos_ok, hit_raw;

    assign h  = {1'b0, conth};
    assign v  = {1'b0, contv};
    assign h0 = {1'b0, ph};
    assign v0 = {1'b0, pv};
    assign h1 = h0 + CS - 11'd1;
    assign v1 = v0 + CS - 11'd1;

    assign in_box  = (h >= h0) && (h <= h1) && (v >= v0) && (v <= v1);
    assign on_edge = in_box && ((h == h0) || (h == h1) || (v == v0) || (v == v1));

    // An anchor outside the visible area hides the cursor entirely, including
    // the crosshair lines that would otherwise still cross the screen.
    assign pos_ok = (h0 < HA) && (v0 < VA);

    always_comb begin
        hit_raw = 1'b0;
        case (mode)
            MODE_SOLID:   hit_raw = in_box;
            MODE_OUTLINE: hit_raw = on_edge;
            MODE_CROSS:   hit_raw = (h == h0) || (v == v0);
            MODE_OFF:     hit_raw = 1'b0;
        endcase
    end

    assign hit = pos_ok & hit_raw;

endmodule

// File: rtl/cursor_compositor.sv
// cursor_compositor
//   Overlays a mouse cursor on a VGA raster. Position, buttons and shape are
//   latched into shadow registers once per frame (CONTV==V_ACTIVE, CONTH==0)
//   so a frame never tears. Two-stage pipeline: stage 1 registers
//   active/hit/buttons/syncs, stage 2 registers colour and syncs, giving a
//   fixed 2-cycle latency from the counters to R/G/B/HSYNC/VSYNC.
//   Ports:
//     clk, rst           : pixel clock, synchronous active-high reset
//     conth, contv       : raster counters from the timing generator
//     hsync_in, vsync_in : raw syncs aligned with the counters
//     posh, posv         : cursor position, top-left anchor
//     bot                : buttons [0] left, [1] right, [2] middle
//     mode               : cursor shape select
//     r, g, b            : registered pixel colour
//     hsync, vsync       : syncs delayed to match colour
//   Build option: CURSOR_BLINK_EN adds a frame counter that blinks the
//   cursor every BLINK_FRAMES frames unless a button is held.
module cursor_compositor
    import cursor_compositor_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int CW           = 1,
    parameter int CUR_SIZE     = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    conth,
    input  logic [9:0]    contv,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [9:0]    posh,
    input  logic [9:0]    posv,
    input  logic [2:0]    bot,
    input  logic [1:0]    mode,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          hsync,
    output logic          vsync
);

    localparam logic [10:0] HA  = 11'(H_ACTIVE);
    localparam logic [10:0] VA  = 11'(V_ACTIVE);
    localparam logic [7:0]  BF8 = 8'(BLINK_FRAMES);

    shadow_t sh;
    logic    frame_latch, active, hit, visible;

    assign frame_latch = ({1'b0, contv} == VA) && (conth == 10'd0);
    assign active      = ({1'b0, conth} < HA) && ({1'b0, contv} < VA);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (frame_latch) begin
            sh <= '{ph: posh, pv: posv, bot: bot, mode: mode};
        end
    end

    cursor_hit #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CUR_SIZE (CUR_SIZE)
    ) u_hit (
        .conth (conth),
        .contv (contv),
        .ph    (sh.ph),
        .pv    (sh.pv),
        .mode  (sh.mode),
        .hit   (hit)
    );

`ifdef CURSOR_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_vis;
    logic [7:0] blink_nxt;

    assign blink_nxt = blink_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= 8'd0;
            blink_vis <= 1'b1;
        end else if (frame_latch) begin
            if (blink_nxt == BF8) begin
                blink_cnt <= 8'd0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_nxt;
            end
        end
    end

    // Holding any button keeps the cursor on regardless of blink phase.
    assign visible = blink_vis | (|sh.bot);
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BF8;
    assign visible          = 1'b1;
`endif

    // Stage 1: geometry result, buttons and syncs.
    logic       act_s1, hit_s1, hs_s1, vs_s1;
    logic [2:0] bot_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_s1 <= 1'b0;
            hit_s1 <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            bot_s1 <= 3'b000;
        end else begin
            act_s1 <= active;
            hit_s1 <= hit & visible;
            hs_s1  <= hsync_in;
            vs_s1  <= vsync_in;
            // Buttons ride with the pixel so a latch event cannot recolour
            // a pixel already in flight.
            bot_s1 <= sh.bot;
        end
    end

    // Stage 2: colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            hsync <= hs_s1;
            vsync <= vs_s1;
            if (act_s1 && hit_s1) begin
                if (bot_s1 == 3'b000) begin
                    r <= '1;
                    g <= '1;
                    b <= '1;
                end else begin
                    r <= {CW{bot_s1[0]}};
                    g <= {CW{bot_s1[1]}};
                    b <= {CW{bot_s1[2]}};
                end
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cursor_compositor.sv
// tb_cursor_compositor
//   Directed vectors for cursor_compositor with hand-computed expectations.
//   Each step drives one raster position and checks the outputs for the
//   position driven two cycles earlier. Observed word is {hsync,vsync,r,g,b}.
module tb_cursor_compositor;
    import cursor_compositor_pkg::*;

`ifdef CURSOR_BLINK_EN
    localparam int BF = 2;
`else
    localparam int BF = 30;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] conth = '0, contv = '0, posh = '0, posv = '0;
    logic       hsync_in = 1'b0, vsync_in = 1'b0;
    logic [2:0] bot = '0;
    logic [1:0] mode = '0;
    logic [0:0] r, g, b;
    logic       hsync, vsync;
    logic [4:0] obs;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_d1 = '0, exp_d2 = '0;
    string      tag_d1 = "init", tag_d2 = "init";

    cursor_compositor #(
        .H_ACTIVE     (640),
        .V_ACTIVE     (480),
        .CW           (1),
        .CUR_SIZE     (8),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .conth    (conth),
        .contv    (contv),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .posh     (posh),
        .posv     (posv),
        .bot      (bot),
        .mode     (mode),
        .r        (r),
        .g        (g),
        .b        (b),
        .hsync    (hsync),
        .vsync    (vsync)
    );

    always #5 clk = ~clk;

    assign obs = {hsync, vsync, r, g, b};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Check the vector from two steps ago, then drive a new one.
    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic hs,
                        input logic vs, input logic [2:0] rgb, input string tag);
        @(negedge clk);
        chk(tag_d2, {27'd0, obs}, {27'd0, exp_d2});
        exp_d2 = exp_d1;
        tag_d2 = tag_d1;
        exp_d1 = {hs, vs, rgb};
        tag_d1 = tag;
        conth    = h;
        contv    = v;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    // Hold reset for n cycles while driving one vector; that vector's result
    // is expected exactly 2 cycles after reset falls, zeros before it.
    task automatic reset_for(input int n, input logic [9:0] h, input logic [9:0] v,
                             input logic hs, input logic vs, input logic [2:0] rgb);
        @(negedge clk);
        rst      = 1'b1;
        conth    = h;
        contv    = v;
        hsync_in = hs;
        vsync_in = vs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_hold", {27'd0, obs}, 32'd0);
        end
        rst    = 1'b0;
        exp_d2 = '0;
        tag_d2 = "rst_gap";
        exp_d1 = {hs, vs, rgb};
        tag_d1 = "rst_first";
    endtask

    // Present new cursor inputs and run one frame latch vector.
    task automatic latch(input logic [9:0] ph, input logic [9:0] pv,
                         input logic [2:0] bt, input logic [1:0] md);
`ifdef CURSOR_BLINK_EN
        // Restart the blink phase so every latched frame starts visible.
        reset_for(1, 10'd700, 10'd600, 1'b0, 1'b0, 3'b000);
`endif
        posh = ph;
        posv = pv;
        bot  = bt;
        mode = md;
        step(10'd0, 10'd480, 1'b0, 1'b0, 3'b000, "latch");
    endtask

`ifdef CURSOR_BLINK_EN
    logic [2:0] bexp [6];
`endif

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        posh = 10'd200;
        posv = 10'd200;
        mode = MODE_CROSS;

        // Reset: outputs zero; afterwards shadow is (0,0) solid white.
        reset_for(3, 10'd0, 10'd0, 1'b1, 1'b1, 3'b111);

        // Test 1: solid box at (100,50).
        latch(10'd100, 10'd50, 3'b000, MODE_SOLID);
        step(10'd100, 10'd50, 1'b0, 1'b0, 3'b111, "t1_tl");
        step(10'd107, 10'd57, 1'b1, 1'b0, 3'b111, "t1_br");
        step(10'd99,  10'd50, 1'b0, 1'b1, 3'b000, "t1_left");
        step(10'd108, 10'd57, 1'b0, 1'b0, 3'b000, "t1_right");
        step(10'd100, 10'd49, 1'b0, 1'b0, 3'b000, "t1_above");
        step(10'd107, 10'd58, 1'b0, 1'b0, 3'b000, "t1_below");
        step(10'd103, 10'd54, 1'b1, 1'b1, 3'b111, "t1_mid");
        step(10'd0,   10'd0,  1'b0, 1'b0, 3'b000, "t1_origin");

        // Test 2: inputs move mid-frame; nothing changes until the latch.
        posh = 10'd300;
        bot  = 3'b001;
        step(10'd104, 10'd53, 1'b0, 1'b0, 3'b111, "t2_old");
        step(10'd304, 10'd53, 1'b0, 1'b0, 3'b000, "t2_notyet");
        step(10'd105, 10'd54, 1'b0, 1'b0, 3'b111, "t2_botheld");
        latch(10'd300, 10'd50, 3'b000, MODE_SOLID);
        step(10'd304, 10'd53, 1'b0, 1'b0, 3'b111, "t2_new");
        step(10'd104, 10'd53, 1'b0, 1'b0, 3'b000, "t2_oldgone");

        // Test 3: outline clipped at the bottom-right corner.
        latch(10'd636, 10'd478, 3'b000, MODE_OUTLINE);
        step(10'd636, 10'd478, 1'b0, 1'b0, 3'b111, "t3_corner");
        step(10'd639, 10'd478, 1'b0, 1'b0, 3'b111, "t3_top_end");
        step(10'd636, 10'd479, 1'b0, 1'b0, 3'b111, "t3_left");
        step(10'd637, 10'd479, 1'b0, 1'b0, 3'b000, "t3_inner");
        step(10'd639, 10'd479, 1'b0, 1'b0, 3'b000, "t3_inner_end");
        step(10'd640, 10'd478, 1'b0, 1'b0, 3'b000, "t3_hclip");
        step(10'd0,   10'd478, 1'b0, 1'b0, 3'b000, "t3_nowrap_h");
        step(10'd636, 10'd0,   1'b0, 1'b0, 3'b000, "t3_nowrap_v");

        // Anchors outside the visible area draw nothing.
        latch(10'd650, 10'd10, 3'b000, MODE_CROSS);
        step(10'd5,   10'd10,  1'b0, 1'b0, 3'b000, "oor_h");
        latch(10'd10, 10'd600, 3'b000, MODE_CROSS);
        step(10'd10,  10'd5,   1'b0, 1'b0, 3'b000, "oor_v");

        // Test 4: magenta crosshair at (320,240).
        latch(10'd320, 10'd240, 3'b101, MODE_CROSS);
        step(10'd320, 10'd0,   1'b0, 1'b0, 3'b101, "t4_col_top");
        step(10'd320, 10'd479, 1'b0, 1'b0, 3'b101, "t4_col_bot");
        step(10'd0,   10'd240, 1'b0, 1'b0, 3'b101, "t4_row_l");
        step(10'd639, 10'd240, 1'b0, 1'b0, 3'b101, "t4_row_r");
        step(10'd321, 10'd241, 1'b0, 1'b0, 3'b000, "t4_miss");
        step(10'd320, 10'd480, 1'b0, 1'b0, 3'b000, "t4_inactive");

        latch(10'd10, 10'd10, 3'b010, MODE_SOLID);
        step(10'd12,  10'd12,  1'b0, 1'b0, 3'b010, "green");
        latch(10'd10, 10'd10, 3'b000, MODE_OFF);
        step(10'd12,  10'd12,  1'b0, 1'b0, 3'b000, "mode_off");
        step(10'd700, 10'd600, 1'b0, 1'b0, 3'b000, "idle");
        step(10'd700, 10'd600, 1'b0, 1'b0, 3'b000, "idle");

        // Test 5: one-cycle reset mid-line; cursor returns to (0,0) solid.
        reset_for(1, 10'd320, 10'd240, 1'b1, 1'b1, 3'b000);
        step(10'd0,   10'd0,   1'b0, 1'b1, 3'b111, "t5_origin");
        step(10'd7,   10'd7,   1'b1, 1'b0, 3'b111, "t5_box");
        step(10'd8,   10'd0,   1'b0, 1'b0, 3'b000, "t5_outside");

`ifdef CURSOR_BLINK_EN
        // Test 6: two frames on, two off; a held button forces red.
        bexp = '{3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 3'b100};
        reset_for(1, 10'd700, 10'd600, 1'b0, 1'b0, 3'b000);
        posh = 10'd10;
        posv = 10'd10;
        mode = MODE_SOLID;
        for (int k = 0; k < 6; k++) begin
            bot = (k == 5) ? 3'b001 : 3'b000;
            step(10'd0,  10'd480, 1'b0, 1'b0, 3'b000, "blink_latch");
            step(10'd12, 10'd12,  1'b0, 1'b0, bexp[k], $sformatf("blink_f%0d", k));
        end
`endif

        step(10'd700, 10'd600, 1'b0, 1'b0, 3'b000, "flush");
        step(10'd700, 10'd600, 1'b0, 1'b0, 3'b000, "flush");
        step(10'd700, 10'd600, 1'b0, 1'b0, 3'b000, "flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
